// File: rtl/ex_stage_pkg.sv
// Shared types for the EX->MEM result stage: flag bundle, entry layout, skid-buffer states.
package ex_stage_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int REG_W_DEFAULT = 5;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] result;
    nzcv_t                    nzcv;
    logic                     set_flags;
    logic [REG_W_DEFAULT-1:0] rd;
    logic                     reg_write;
  } ex_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/zero_detect_64.sv
// 64-input reduction-NOR split into eight byte-wide OR groups; also used by the CBZ compare.
module zero_detect_64 (
  input  logic [63:0] data_i,
  output logic        zero_o
);

  logic [7:0] group_or;

  for (genvar g = 0; g < 8; g++) begin : g_group
    assign group_or[g] = |data_i[g*8 +: 8];
  end

  assign zero_o = ~|group_or;

endmodule

// File: rtl/ex_result_stage.sv
// EX->MEM result stage: 2-entry skid buffer, N/Z derivation at capture, NZCV commit on output.
// Define FLAG_BYPASS_EN to expose the head entry's flags combinationally on flags_nzcv.
module ex_result_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             set_flags,
  input  logic [REG_W-1:0] rd,
  input  logic             reg_write,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [REG_W-1:0] out_rd,
  output logic             out_reg_write,
  output logic [3:0]       flags_nzcv,
  output skid_state_t      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid is never withdrawn by this stage, and in_ready is a register, not a path from out_ready.

  typedef struct packed {
    logic [WIDTH-1:0] result;
    nzcv_t            nzcv;
    logic             set_flags;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } entry_t;

  entry_t      head_q, head_d, skid_q, skid_d, new_entry;
  skid_state_t state_q, state_d;
  nzcv_t       flags_q, flags_d;
  logic        in_ready_q;
  logic        in_xfer, out_xfer, result_zero;
  logic [63:0] zd_data;

  // Zero detect is a fixed 64-bit tree; narrower datapaths are zero-extended into it.
  assign zd_data = 64'(alu_result);

  zero_detect_64 u_zero_detect (
    .data_i (zd_data),
    .zero_o (result_zero)
  );

  always_comb begin
    new_entry           = '0;
    new_entry.result    = alu_result;
    new_entry.nzcv.n    = alu_result[WIDTH-1];
    new_entry.nzcv.z    = result_zero;
    new_entry.nzcv.c    = alu_carry;
    new_entry.nzcv.v    = alu_overflow;
    new_entry.set_flags = set_flags;
    new_entry.rd        = rd;
    new_entry.reg_write = reg_write;
  end

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    flags_d = flags_q;
    // MEM has consumed the head even when a flush lands on the same edge.
    if (out_xfer && head_q.set_flags) flags_d = head_q.nzcv;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          head_d  = new_entry;
          state_d = ONE;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = new_entry;
          end else if (in_xfer) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_xfer) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      flags_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      flags_q    <= flags_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_result    = head_q.result;
  assign out_rd        = head_q.rd;
  assign out_reg_write = out_valid & head_q.reg_write;
  assign dbg_state     = state_q;

`ifdef FLAG_BYPASS_EN
  assign flags_nzcv = (out_valid && head_q.set_flags) ? head_q.nzcv : flags_q;
`else
  assign flags_nzcv = flags_q;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed scenarios plus random traffic against a queue-based model.
module tb_ex_result_stage;
  import ex_stage_pkg::*;

  localparam int W = 75;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] alu_result = '0;
  logic        alu_carry = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        set_flags = 1'b0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [3:0]  flags_nzcv;
  skid_state_t dbg_state;

  int tests = 0;
  int fails = 0;

  // Expected entries: [74:11] result, [10:6] rd, [5] reg_write, [4] set_flags, [3:0] nzcv
  logic [W-1:0] exp_q[$];
  logic [3:0]   flags_m = 4'b0000;
  bit           ready_m = 1'b1;

  ex_result_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .set_flags     (set_flags),
    .rd            (rd),
    .reg_write     (reg_write),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .flags_nzcv    (flags_nzcv),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_entry(input logic [63:0] r, input logic c, input logic v,
                                            input logic sf, input logic [4:0] d, input logic rw);
    logic [3:0] nz;
    nz = {r[63], (r == 64'd0), c, v};
    return {r, d, rw, sf, nz};
  endfunction

  // Input side of the model: record what the stage should accept.
  always @(posedge clk) begin
    if (reset) begin
      if (flush) exp_q.delete();
      else if (in_valid && ready_m)
        exp_q.push_back(mk_entry(alu_result, alu_carry, alu_overflow, set_flags, rd, reg_write));
    end
  end

  // Output side: compare presented head against the model, then retire on handshake.
  always @(negedge clk) begin : monitor
    logic [W-1:0] h;
    logic [3:0]   exp_flags;
    skid_state_t  exp_st;
    bit           have;
    if (reset) begin
      have = (exp_q.size() > 0);
      h = have ? exp_q[0] : '0;
      exp_st = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? ONE : FULL;
      check("out_valid", 64'(out_valid), 64'(have));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      check("state", 64'(dbg_state), 64'(exp_st));
`ifdef FLAG_BYPASS_EN
      exp_flags = (have && h[4]) ? h[3:0] : flags_m;
`else
      exp_flags = flags_m;
`endif
      check("flags", 64'(flags_nzcv), 64'(exp_flags));
      if (have) begin
        check("out_result", out_result, h[74:11]);
        check("out_rd", 64'(out_rd), 64'(h[10:6]));
        check("out_reg_write", 64'(out_reg_write), 64'(h[5]));
      end else begin
        check("out_reg_write_idle", 64'(out_reg_write), 64'd0);
      end
      ready_m = (exp_q.size() < 2);
      if (have && out_ready) begin
        void'(exp_q.pop_front());
        if (h[4]) flags_m = h[3:0];
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [63:0] r, input logic c, input logic v,
                            input logic sf, input logic [4:0] d, input logic rw);
    alu_result = r; alu_carry = c; alu_overflow = v;
    set_flags = sf; rd = d; reg_write = rw;
  endtask

  task automatic send(input logic [63:0] r, input logic c, input logic v,
                      input logic sf, input logic [4:0] d, input logic rw);
    bit acc;
    acc = 1'b0;
    set_fields(r, c, v, sf, d, rw);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(posedge clk);
      acc = in_ready;
      #1;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_flags", 64'(flags_nzcv), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_reg_write", 64'(out_reg_write), 64'd0);
    reset = 1'b1;
    idle(3);

    // ANDS with negative result
    out_ready = 1'b1;
    send(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1);
    check("ands_latency", 64'(out_valid), 64'd1);
    cyc();
    check("ands_flags", 64'(flags_nzcv), 64'h8);

    // backpressure with three inputs
    out_ready = 1'b0;
    send(64'd1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    send(64'd2, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    set_fields(64'd3, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    in_valid = 1'b1;
    cyc();
    cyc();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(64'd3, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    idle(4);

    // zero-result SUBS then non-flag-setting ADD
    send(64'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
    send(64'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    idle(3);
    check("subs_flags", 64'(flags_nzcv), 64'h6);

    // flush while FULL with a competing input
    out_ready = 1'b0;
    send(64'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
    send(64'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    set_fields(64'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    in_valid = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_flags", 64'(flags_nzcv), 64'h6);
    idle(2);

    // head with set_flags and zero result, held by backpressure
    send(64'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0);
`ifdef FLAG_BYPASS_EN
    check("bypass_flags_early", 64'(flags_nzcv), 64'h4);
`else
    check("bypass_flags_early", 64'(flags_nzcv), 64'h6);
`endif
    out_ready = 1'b1;
    cyc();
    check("bypass_flags_commit", 64'(flags_nzcv), 64'h4);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [63:0] r;
      case ($urandom_range(0, 3))
        0:       r = 64'd0;
        1:       r = {1'b1, 31'($urandom), 32'($urandom)};
        default: r = {32'($urandom), 32'($urandom)};
      endcase
      set_fields(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      cyc();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    // asynchronous reset while holding entries
    out_ready = 1'b0;
    send(64'h1234, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1);
    send(64'h5678, 1'b0, 1'b1, 1'b1, 5'd12, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_flags", 64'(flags_nzcv), 64'd0);
    exp_q.delete();
    flags_m = 4'b0000;
    ready_m = 1'b1;
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    idle(3);
    send(64'hffff_ffff_ffff_ffff, 1'b1, 1'b0, 1'b1, 5'd31, 1'b1);
    idle(3);
    check("post_rst_flags", 64'(flags_nzcv), 64'ha);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
